// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with load-use stall, branch flush, hold and a
// saturating bubble counter.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// RUN         | normal flow; execute holds the last loaded instruction
// LU_BUBBLE   | a load-use bubble was inserted; decode instruction is re-offered
// FLUSHED     | a taken-branch bubble was inserted; decode was squashed
module decode_execute_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,

    input  logic                      REG_WRITE_D,
    input  logic                      MEM_TO_REG_D,
    input  logic                      MEM_WRITE_D,
    input  logic                      BRANCH_D,
    input  logic [3:0]                ALU_CONTROL_D,
    input  logic [1:0]                ALU_SRC_D,
    input  logic [DATA_WIDTH-1:0]     RD1_D,
    input  logic [DATA_WIDTH-1:0]     RD2_D,
    input  logic [DATA_WIDTH-1:0]     IMM_D,
    input  logic [REG_ADDR_WIDTH-1:0] RS_D,
    input  logic [REG_ADDR_WIDTH-1:0] RT_D,
    input  logic [REG_ADDR_WIDTH-1:0] RD_D,
    input  logic                      BRANCH_TAKEN_E,
    input  logic                      HOLD,

    output logic                      REG_WRITE_E,
    output logic                      MEM_TO_REG_E,
    output logic                      MEM_WRITE_E,
    output logic                      BRANCH_E,
    output logic [3:0]                ALU_CONTROL_E,
    output logic [1:0]                ALU_SRC_E,
    output logic [DATA_WIDTH-1:0]     RD1_E,
    output logic [DATA_WIDTH-1:0]     RD2_E,
    output logic [DATA_WIDTH-1:0]     IMM_E,
    output logic [REG_ADDR_WIDTH-1:0] RS_E,
    output logic [REG_ADDR_WIDTH-1:0] RT_E,
    output logic [REG_ADDR_WIDTH-1:0] RD_E,
    output logic                      VALID_E,
    output logic                      STALL_D,
    output logic                      FLUSH_D,
    output logic [15:0]               BUBBLE_COUNT
);

    localparam logic [1:0]  ST_RUN       = 2'd0;
    localparam logic [1:0]  ST_LU_BUBBLE = 2'd1;
    localparam logic [1:0]  ST_FLUSHED   = 2'd2;

    // A bubble must decode as a harmless no-op in execute.
    localparam logic [3:0]  BUBBLE_ALU_CONTROL = 4'b1111;
    localparam logic [1:0]  BUBBLE_ALU_SRC     = 2'b01;
    localparam logic [15:0] COUNT_MAX          = 16'hFFFF;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       load_use;
    logic       take_flush;
    logic       take_lu;
    logic       take_load;
    logic       insert_bubble;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = VALID_E && MEM_TO_REG_E && (RD_E != '0) &&
                      ((RD_E == RS_D) || (RD_E == RT_D));

    // Priority of the update rules below reset: hold, branch flush, load-use, load.
    always_comb begin
        take_flush = 1'b0;
        take_lu    = 1'b0;
        take_load  = 1'b0;
        if (!RESET && !HOLD) begin
            if (BRANCH_TAKEN_E) begin
                take_flush = 1'b1;
            end else if (load_use) begin
                take_lu = 1'b1;
            end else begin
                take_load = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (take_flush) begin
            state_d = ST_FLUSHED;
        end else if (take_lu) begin
            state_d = ST_LU_BUBBLE;
        end else if (take_load) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        STALL_D       = (load_use && !BRANCH_TAKEN_E) || HOLD;
        FLUSH_D       = BRANCH_TAKEN_E && !HOLD;
        insert_bubble = take_flush || take_lu;
    end

    always_ff @(posedge CLK) begin
        if (RESET || insert_bubble) begin
            REG_WRITE_E   <= 1'b0;
            MEM_TO_REG_E  <= 1'b0;
            MEM_WRITE_E   <= 1'b0;
            BRANCH_E      <= 1'b0;
            ALU_CONTROL_E <= BUBBLE_ALU_CONTROL;
            ALU_SRC_E     <= BUBBLE_ALU_SRC;
            RD1_E         <= '0;
            RD2_E         <= '0;
            IMM_E         <= '0;
            RS_E          <= '0;
            RT_E          <= '0;
            RD_E          <= '0;
            VALID_E       <= 1'b0;
        end else if (take_load) begin
            REG_WRITE_E   <= REG_WRITE_D;
            MEM_TO_REG_E  <= MEM_TO_REG_D;
            MEM_WRITE_E   <= MEM_WRITE_D;
            BRANCH_E      <= BRANCH_D;
            ALU_CONTROL_E <= ALU_CONTROL_D;
            ALU_SRC_E     <= ALU_SRC_D;
            RD1_E         <= RD1_D;
            RD2_E         <= RD2_D;
            IMM_E         <= IMM_D;
            RS_E          <= RS_D;
            RT_E          <= RT_D;
            RD_E          <= RD_D;
            VALID_E       <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUBBLE_COUNT <= '0;
        end else if (insert_bubble && (BUBBLE_COUNT != COUNT_MAX)) begin
            BUBBLE_COUNT <= BUBBLE_COUNT + 16'd1;
        end
    end

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the operand width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning the register-index width.
REQ-003 SHALL have these ports; the block uses one clock, and reset is synchronous and active-high:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous active-high reset.
- REG_WRITE_D, MEM_TO_REG_D, MEM_WRITE_D, BRANCH_D  in  1 each  decoded controls.
- ALU_CONTROL_D  in  4  decoded ALU operation.
- ALU_SRC_D  in  2  decoded ALU source select.
- RD1_D, RD2_D, IMM_D  in  DATA_WIDTH each  operands and sign-extended immediate.
- RS_D, RT_D, RD_D  in  REG_ADDR_WIDTH each  source and destination indices.
- BRANCH_TAKEN_E  in  1  branch in execute resolved taken.
- HOLD  in  1  downstream busy; freeze the execute stage.
- Outputs: each *_D data and control input has a registered *_E output of equal width.
- VALID_E  out  1  execute stage holds a real instruction.
- STALL_D  out  1  freeze fetch and decode this cycle.
- FLUSH_D  out  1  squash decode this cycle.
- BUBBLE_COUNT  out  16  bubbles inserted so far; saturating.

Function
REQ-004 A bubble SHALL set REG_WRITE_E=0, MEM_TO_REG_E=0, MEM_WRITE_E=0, BRANCH_E=0, ALU_CONTROL_E=4'b1111, ALU_SRC_E=2'b01 and VALID_E=0; data and index outputs SHALL be zero.
REQ-005 Load-use hazard (LU) SHALL be asserted when VALID_E=1 and MEM_TO_REG_E=1 and RD_E≠0 and (RD_E==RS_D or RD_E==RT_D).
REQ-006 Each rising edge SHALL update the stage by the first matching rule:
- RESET: load a bubble.
- HOLD: keep all *_E outputs.
- BRANCH_TAKEN_E: load a bubble.
- LU: load a bubble.
- Otherwise: load the *_D inputs and set VALID_E=1.
REQ-007 STALL_D SHALL be combinational: LU and not BRANCH_TAKEN_E, OR HOLD.
REQ-008 FLUSH_D SHALL be combinational: BRANCH_TAKEN_E and not HOLD.
REQ-009 The FSM SHALL have states RUN, LU_BUBBLE and FLUSHED; reset state is RUN.
REQ-010 The FSM SHALL move to LU_BUBBLE on the edge where the LU rule (REQ-006) applies.
REQ-011 The FSM SHALL move to FLUSHED on the edge where the BRANCH_TAKEN_E rule applies.
REQ-012 The FSM SHALL return to RUN on the edge where the load rule applies.
REQ-013 The FSM SHALL stay in its current state on the edge where the HOLD rule applies.
REQ-014 In LU_BUBBLE, LU SHALL be evaluated again; it is normally false because the bubble clears MEM_TO_REG_E, so the stall lasts exactly one cycle.
REQ-015 BUBBLE_COUNT SHALL increment by 1 on each edge where the BRANCH_TAKEN_E or LU rule applies, and SHALL saturate at 16'hFFFF with no wrap.
REQ-016 Data latency from the *_D inputs to the *_E outputs SHALL be 1 cycle when no hazard is present.
REQ-017 When BRANCH_TAKEN_E and LU are true together, the flush SHALL win: one bubble, STALL_D=0, FLUSH_D=1, and the count increments by 1.
REQ-018 When HOLD and BRANCH_TAKEN_E are true together, the stage SHALL hold with FLUSH_D=0; the flush takes effect on the first cycle after HOLD deasserts.
REQ-019 An LU comparison on register index 0 SHALL never stall.

Reset
REQ-020 While RESET=1, on every edge the outputs SHALL be a bubble (REQ-004), BUBBLE_COUNT SHALL be 0 and the FSM SHALL be in RUN, regardless of HOLD.
REQ-021 STALL_D and FLUSH_D SHALL be 0 during the first cycle after reset.
REQ-022 Reset asserted mid-stall or mid-flush SHALL abandon that operation, with no residual stall after release.

Verification
REQ-023 The bench SHALL cover passthrough: ADD controls {1,0,0,0000,00,0} with RD1_D=5 and RD2_D=7 -> next cycle the same values on *_E, VALID_E=1 and STALL_D=0.
REQ-024 The bench SHALL cover load-use: a LW with RD_E=3 in E and RS_D=3 -> STALL_D=1 for 1 cycle, bubble with ALU_CONTROL_E=1111, BUBBLE_COUNT=1, then the held instruction enters E.
REQ-025 The bench SHALL cover branch flush: BRANCH_TAKEN_E=1 for 1 cycle -> FLUSH_D=1, VALID_E=0 on the next cycle, state FLUSHED then RUN.
REQ-026 The bench SHALL cover simultaneous branch and LU -> exactly 1 bubble, STALL_D=0, FLUSH_D=1, count +1.
REQ-027 The bench SHALL cover HOLD for 3 cycles with a branch pending -> *_E outputs stable and FLUSH_D=0, then flush in the cycle after release.
REQ-028 The bench SHALL cover saturation: preload 16'hFFFE and force 3 bubbles -> BUBBLE_COUNT=16'hFFFF; then RESET -> 0.
